// File: rtl/display_scanner.sv
// Time-multiplexes three 7-segment codes onto one shared segment bus and three digit selects.
// Outputs register the next-state slot with zero added latency; no backpressure, and new codes take effect only at frame wrap.
module display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] display_1_i,
    input  logic [6:0] display_2_i,
    input  logic [6:0] display_3_i,
    input  logic       load_i,
    input  logic [2:0] digits_en_i,
    output logic [6:0] seg_o,
    output logic [2:0] an_o,
    output logic       frame_o
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_OFF   = 7'h7F;
    localparam logic [2:0]    AN_OFF    = 3'b111;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [1:0]        idx;
    logic [1:0]        idx_n;
    logic [2:0][6:0]   shadow;
    logic [2:0][6:0]   active;
    logic [2:0][6:0]   active_n;
    logic              pending;
    logic              slot_end;
    logic              wrap;
    logic              blank;
    logic [6:0]        seg_n;
    logic [2:0]        an_n;

    always_comb begin
        slot_end = (cnt == CNT_LAST);
        wrap     = slot_end && (idx == 2'd2);
        cnt_n    = slot_end ? '0 : cnt + 1'b1;
        if (!slot_end)
            idx_n = idx;
        else if (idx == 2'd2)
            idx_n = 2'd0;
        else
            idx_n = idx + 2'd1;
        // Active is taken from the shadow contents before this edge's load,
        // so a load landing on the wrap edge waits a full frame.
        active_n = (wrap && pending) ? shadow : active;
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (cnt_n < BLANK_LIM);
        end
    endgenerate

    always_comb begin
        seg_n = SEG_OFF;
        an_n  = AN_OFF;
        if (!blank && digits_en_i[idx_n]) begin
            seg_n = active_n[idx_n];
            an_n  = ~(3'b001 << idx_n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            idx     <= 2'd0;
            shadow  <= {3{SEG_OFF}};
            active  <= {3{SEG_OFF}};
            pending <= 1'b0;
            seg_o   <= SEG_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            idx    <= idx_n;
            active <= active_n;
            if (load_i) begin
                shadow  <= {display_3_i, display_2_i, display_1_i};
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
            seg_o   <= seg_n;
            an_o    <= an_n;
            frame_o <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: a cycle model feeds a scoreboard queue, plus targeted checks.
module tb_display_scanner;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] an;
        logic       frame;
    } exp_t;

    typedef struct {
        int              p;
        logic [2:0][6:0] sh;
        logic [2:0][6:0] act;
        logic            pend;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [6:0] d1 = 7'h7F, d2 = 7'h7F, d3 = 7'h7F;
    logic [2:0] en = 3'b111;
    logic [2:0] en2 = 3'b111;
    logic [6:0] seg1, seg2;
    logic [2:0] an1, an2;
    logic       frame1, frame2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_f2 = 0;
    bit seen_f2 = 0;
    logic prev_rst = 1'b1;
    mst_t m1, m2;
    exp_t q1[$], q2[$];

    display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .display_1_i(d1), .display_2_i(d2), .display_3_i(d3),
        .load_i(load), .digits_en_i(en), .seg_o(seg1), .an_o(an1), .frame_o(frame1));

    display_scanner #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .display_1_i(d1), .display_2_i(d2), .display_3_i(d3),
        .load_i(load), .digits_en_i(en2), .seg_o(seg2), .an_o(an2), .frame_o(frame2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic mstep(input int r, input int b, input logic rs, input logic ld,
                         input logic [2:0][6:0] codes, input logic [2:0] e,
                         input mst_t mi, output mst_t mo, output exp_t ex);
        bit w;
        int s, k;
        mo = mi;
        ex.seg = 7'h7F;
        ex.an = 3'b111;
        ex.frame = 1'b0;
        if (rs) begin
            mo.p = 0;
            mo.sh = {3{7'h7F}};
            mo.act = {3{7'h7F}};
            mo.pend = 1'b0;
        end else begin
            w = ((mi.p % r) == r - 1) && (((mi.p / r) % 3) == 2);
            if (w && mi.pend) begin
                mo.act = mi.sh;
                mo.pend = 1'b0;
            end
            if (ld) begin
                mo.sh = codes;
                mo.pend = 1'b1;
            end
            mo.p = (mi.p + 1) % (3 * r);
            s = mo.p % r;
            k = mo.p / r;
            ex.frame = w;
            if (s >= b && e[k]) begin
                ex.seg = mo.act[k];
                ex.an = 3'b111 & ~(3'b001 << k);
            end
        end
    endtask

    task automatic step();
        exp_t e1, e2;
        mstep(8, 2, rst, load, {d3, d2, d1}, en, m1, m1, e1);
        q1.push_back(e1);
        mstep(2, 0, rst, load, {d3, d2, d1}, en2, m2, m2, e2);
        q2.push_back(e2);
        prev_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        chk("seg", 32'(seg1), 32'(e1.seg));
        chk("an", 32'(an1), 32'(e1.an));
        chk("frame", 32'(frame1), 32'(e1.frame));
        chk("onehot", 32'($countones(~an1) <= 1), 32'd1);
        chk("seg2", 32'(seg2), 32'(e2.seg));
        chk("an2", 32'(an2), 32'(e2.an));
        chk("frame2", 32'(frame2), 32'(e2.frame));
        if (prev_rst) begin
            seen_f2 = 0;
        end else begin
            chk("nogap2", 32'(an2 != 3'b111), 32'd1);
            if (frame2) begin
                if (seen_f2) chk("fperiod2", 32'(cyc - last_f2), 32'd6);
                last_f2 = cyc;
                seen_f2 = 1;
            end
        end
    endtask

    initial begin
        int nf, n110, n011;
        m1 = '{p: 0, sh: {3{7'h7F}}, act: {3{7'h7F}}, pend: 1'b0};
        m2 = m1;

        // Reset
        step();
        step();
        chk("rst_seg", 32'(seg1), 32'h7F);
        chk("rst_an", 32'(an1), 32'h7);
        chk("rst_frame", 32'(frame1), 32'd0);
        rst = 1'b0;

        // Test 1: free-running scan, one frame pulse after 24 cycles
        nf = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (frame1) nf++;
        end
        chk("t1_frame_last", 32'(frame1), 32'd1);
        chk("t1_frame_count", 32'(nf), 32'd1);

        // Test 2: mid-frame load, held until the next wrap
        for (int i = 0; i < 4; i++) step();
        d1 = 7'h40; d2 = 7'h79; d3 = 7'h24; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 19; i++) begin
            step();
            chk("t2_hold", 32'(seg1), 32'h7F);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (an1 == 3'b110) chk("t2_d1", 32'(seg1), 32'h40);
            if (an1 == 3'b101) chk("t2_d2", 32'(seg1), 32'h79);
            if (an1 == 3'b011) chk("t2_d3", 32'(seg1), 32'h24);
        end

        // Test 3: load on the wrap edge applies one frame late
        for (int i = 0; i < 23; i++) step();
        d1 = 7'h30; d2 = 7'h30; d3 = 7'h30; load = 1'b1;
        step();
        load = 1'b0;
        chk("t3_wrap_frame", 32'(frame1), 32'd1);
        for (int i = 0; i < 24; i++) begin
            step();
            if (an1 == 3'b110) chk("t3_old_d1", 32'(seg1), 32'h40);
            if (an1 == 3'b101) chk("t3_old_d2", 32'(seg1), 32'h79);
            if (an1 == 3'b011) chk("t3_old_d3", 32'(seg1), 32'h24);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (an1 != 3'b111) chk("t3_new", 32'(seg1), 32'h30);
        end

        // Test 4: digit 2 disabled, slot still consumed
        en = 3'b101;
        n110 = 0;
        n011 = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            chk("t4_d2off", 32'(an1 == 3'b101), 32'd0);
            if (an1 == 3'b110) n110++;
            if (an1 == 3'b011) n011++;
        end
        chk("t4_d1_cycles", 32'(n110), 32'd6);
        chk("t4_d3_cycles", 32'(n011), 32'd6);
        chk("t4_timing", 32'(frame1), 32'd1);
        en = 3'b111;

        // Test 6: reset mid-slot discards a pending load
        for (int i = 0; i < 3; i++) step();
        d1 = 7'h00; d2 = 7'h00; d3 = 7'h00; load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_seg", 32'(seg1), 32'h7F);
        chk("t6_an", 32'(an1), 32'h7);
        chk("t6_frame", 32'(frame1), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step();
            chk("t6_discard", 32'(seg1), 32'h7F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
